// File: rtl/serial_add_ctrl_if.sv
// Requester <-> bit-serial adder controller signal bundle; `sub` exists only with SERIAL_ADD_SUB_EN.
// master = requester side, slave = controller side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller, LSB first, one bit per clk; WIDTH+1 cycles start->idle. Optional subtract: SERIAL_ADD_SUB_EN.
// No backpressure or queueing: start is accepted only in IDLE and ignored in RUN/DONE.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sum_sr;
  logic             cout_r;
  logic             last_bit;
  logic             s_bit;
  logic             c_nxt;
  logic             sub_mode;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_mode = bus.sub;
`else
  assign sub_mode = 1'b0;
`endif

  // The single shared full-adder cell
  assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nxt    = ((a_sr[0] ^ b_sr[0]) & carry) | (a_sr[0] & b_sr[0]);
  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
    bus.sum  = sum_sr;
    bus.cout = cout_r;
  end

  // Subtract is a + ~b + 1: invert b once at capture and seed the carry with 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_sr <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= sub_mode ? ~bus.b : bus.b;
            carry <= sub_mode ? 1'b1 : bus.cin;
            count <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_nxt;
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          count  <= count + CW'(1);
          if (last_bit) cout_r <= c_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table plus handshake/reset corner sequences.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();
  serial_add_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int             checks = 0;
  int             errors = 0;
  int             done_seen = 0;
  int             cyc;
  int             d0;
  int             nvec;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] sb_e;
  vec_t           vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: subtract vector skipped in add-only build");
`endif
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 sum=%0h required no pulse", bus.sum);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_sum", 32'(bus.sum), 32'(sb_e[WIDTH-1:0]));
        chk("sb_cout", 32'(bus.cout), 32'(sb_e[WIDTH]));
      end
    end
  end

  // Called #1 after a posedge with the DUT idle and operands set; returns #1 after the edge into IDLE
  task automatic run_op(input string tag, input logic [WIDTH:0] exp);
    int n;
    int bcyc;
    exp_q.push_back(exp);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    bcyc = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      if (bus.busy) bcyc++;
      n++;
    end
    chk({tag, "_busy_cycles"}, 32'(bcyc), 32'(WIDTH));
    chk({tag, "_latency"}, 32'(n), 32'(WIDTH + 1));
    @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_sum_hold"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
    chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    set_ops('0, '0, 1'b0, 1'b0);

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    nvec = 8;
`ifdef SERIAL_ADD_SUB_EN
    vecs[8]  = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
    vecs[9]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[10] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[11] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0};
    nvec = 12;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < nvec; i++) begin
      set_ops(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      run_op($sformatf("vec%0d", i), {vecs[i].cout, vecs[i].sum});
    end
    set_ops(8'h00, 8'h00, 1'b0, 1'b0);

    // start held high across two ops, operands changed mid-RUN
    d0 = done_seen;
    set_ops(8'h01, 8'h02, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'h30});
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    set_ops(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done(cyc);
    chk("hold_lat1", 32'(cyc), 32'(WIDTH + 1));
    @(posedge clk);
    #1;
    chk("hold_start_in_done_ignored", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk("hold_next_idle_accepts", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("hold_lat2", 32'(cyc), 32'(WIDTH + 1));
    @(posedge clk);
    #1;
    chk("hold_done_count", 32'(done_seen - d0), 32'd2);
    chk("hold_sb_drained", 32'(exp_q.size()), 32'd0);

    // start raised only once DONE is visible: ignored there, accepted in the next IDLE
    @(posedge clk);
    #1;
    d0 = done_seen;
    set_ops(8'h0F, 8'h01, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 8'h10});
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc);
    chk("b2b_lat", 32'(cyc), 32'(WIDTH + 1));
    set_ops(8'h22, 8'h11, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 8'h34});
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_done_start_ignored", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_idle_start_accepted", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("b2b_lat2", 32'(cyc), 32'(WIDTH + 1));
    @(posedge clk);
    #1;
    chk("b2b_done_count", 32'(done_seen - d0), 32'd2);

    // reset sampled at E4 of a RUN
    set_ops(8'hFF, 8'h00, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_busy_before_rst", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
    chk("midrun_rst_done", 32'(bus.done), 32'd0);
    chk("midrun_rst_sum", 32'(bus.sum), 32'd0);
    chk("midrun_rst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (12) @(posedge clk);
    #1;
    chk("midrun_no_done", 32'(done_seen - d0), 32'd0);
    set_ops(8'h12, 8'h34, 1'b1, 1'b0);
    run_op("post_rst", {1'b0, 8'h47});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
